cpu_program_sequencer: RTL

//  Instruction sequencer for the 8-bit CPU: owns the program counter, fetches 16-bit words

---
 rtl/cpu_program_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_program_sequencer.sv
// cpu_program_sequencer
//   Instruction sequencer for the 8-bit CPU. It owns the program counter and
//   fetches 16-bit words from a synchronous program ROM. Flag-conditional
//   jumps and HALT are resolved locally. Every other opcode is handed to the
//   execute FSM over a valid/ready handshake. The sequencer can free-run or
//   execute single steps.
//
//   Word format: [15:11] opcode, [10:8] cond, [7:0] target.
//   Reserved opcodes: 1F HALT, 1E JMP, 1D CALL, 1C RET.
//
//   Optional feature macro: SEQ_CALL_EN
//     When defined, adds a one-deep return register for CALL/RET.
//     When undefined, CALL and RET behave as NOPs.
//
// Ports
//   clk_i, rst_i            clock; asynchronous active-high reset
//   run_i                   level: free-run while high
//   step_i                  rising edge: execute exactly one instruction
//   imem_addr_o/imem_data_i ROM address (= PC); data arrives one cycle later
//   z_i, c_i, n_i, v_i      registered ALU flags
//   op_o, op_valid_o        opcode issued to execute FSM, held until op_ready_i
//   op_ready_i              execute FSM accepts op_o
//   pc_o                    current PC (debug)
//   busy_o, halted_o        status
module cpu_program_sequencer #(
  parameter int unsigned PC_W = 8,
  parameter int unsigned OP_W = 5
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            step_i,
  output logic [PC_W-1:0] imem_addr_o,
  input  logic [15:0]     imem_data_i,
  input  logic            z_i,
  input  logic            c_i,
  input  logic            n_i,
  input  logic            v_i,
  output logic [OP_W-1:0] op_o,
  output logic            op_valid_o,
  input  logic            op_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic            busy_o,
  output logic            halted_o
);

  localparam logic [4:0] OPC_HALT = 5'h1F;
  localparam logic [4:0] OPC_JMP  = 5'h1E;
  localparam logic [4:0] OPC_CALL = 5'h1D;
  localparam logic [4:0] OPC_RET  = 5'h1C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_HALTED
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [OP_W-1:0] op_q, op_d;
  logic            op_valid_q, op_valid_d;
  logic            step_mode_q, step_mode_d;
  logic            step_prev_q;
`ifdef SEQ_CALL_EN
  logic [PC_W-1:0] ret_pc_q, ret_pc_d;
`endif

  logic [4:0]      opcode;
  logic [2:0]      cond;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] pc_inc;
  logic            step_rise;
  logic            cond_true;
  state_t          after_instr;

  assign opcode    = imem_data_i[15:11];
  assign cond      = imem_data_i[10:8];
  assign target    = PC_W'(imem_data_i[7:0]);
  assign pc_inc    = pc_q + PC_W'(1);
  assign step_rise = step_i & ~step_prev_q;

  // Single-step instructions always return to IDLE, even if run_i rose meanwhile.
  assign after_instr = (run_i && !step_mode_q) ? S_FETCH : S_IDLE;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      3'd0: cond_true = 1'b1;
      3'd1: cond_true = z_i;
      3'd2: cond_true = ~z_i;
      3'd3: cond_true = c_i;
      3'd4: cond_true = ~c_i;
      3'd5: cond_true = n_i;
      3'd6: cond_true = v_i;
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    op_valid_d  = op_valid_q;
    step_mode_d = step_mode_q;
`ifdef SEQ_CALL_EN
    ret_pc_d    = ret_pc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (run_i || step_rise) begin
          state_d     = S_FETCH;
          step_mode_d = ~run_i;
        end
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (opcode)
          OPC_HALT: begin
            state_d = S_HALTED;
          end
          OPC_JMP: begin
            pc_d    = cond_true ? target : pc_inc;
            state_d = after_instr;
          end
          OPC_CALL: begin
`ifdef SEQ_CALL_EN
            ret_pc_d = pc_inc;
            pc_d     = target;
`else
            pc_d     = pc_inc;
`endif
            state_d  = after_instr;
          end
          OPC_RET: begin
`ifdef SEQ_CALL_EN
            pc_d    = ret_pc_q;
`else
            pc_d    = pc_inc;
`endif
            state_d = after_instr;
          end
          default: begin
            op_d       = OP_W'(opcode);
            op_valid_d = 1'b1;
            pc_d       = pc_inc;
            state_d    = S_ISSUE;
          end
        endcase
      end
      S_ISSUE: begin
        if (op_ready_i) begin
          op_valid_d = 1'b0;
          state_d    = after_instr;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      op_q        <= '0;
      op_valid_q  <= 1'b0;
      step_mode_q <= 1'b0;
      step_prev_q <= 1'b0;
`ifdef SEQ_CALL_EN
      ret_pc_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      op_q        <= op_d;
      op_valid_q  <= op_valid_d;
      step_mode_q <= step_mode_d;
      step_prev_q <= step_i;
`ifdef SEQ_CALL_EN
      ret_pc_q    <= ret_pc_d;
`endif
    end
  end

  assign imem_addr_o = pc_q;
  assign pc_o        = pc_q;
  assign op_o        = op_q;
  assign op_valid_o  = op_valid_q;
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_HALTED);
  assign halted_o    = (state_q == S_HALTED);

endmodule
